// File: rtl/axis_gate_sequencer.sv
// -----------------------------------------------------------------------------
// axis_gate_sequencer
//
// Table-driven command source for axis_gate_controller. A host loads gate
// entries into an internal table. The block then plays the first cfg_length
// entries in order as 128-bit AXI4-Stream beats. It replays that list
// cfg_loops times, or forever when cfg_loops is 0.
//
// Ports
//   aclk           clock
//   aresetn        asynchronous active-low reset
//   cfg_wren       table write strobe (accepted in any state)
//   cfg_addr       table write address
//   cfg_wdata      entry {gate[112], level[111:96], poff[95:64], duration[63:0]}
//   cfg_length     entries per pass (1..DEPTH, larger values clamp to DEPTH)
//   cfg_loops      passes per run, 0 = endless
//   start          single-cycle run request (ignored while busy)
//   stop           single-cycle abort request (wins over start)
//   m_axis_tready  downstream ready
//   m_axis_tdata   {15'd0, entry}
//   m_axis_tvalid  command valid
//   busy           high whenever the sequencer is not idle
//   loop_cntr      completed passes in the current or most recent run
// -----------------------------------------------------------------------------
module axis_gate_sequencer #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cfg_wren,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [112:0]          cfg_wdata,
    input  logic [ADDR_WIDTH:0]   cfg_length,
    input  logic [31:0]           cfg_loops,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  m_axis_tready,
    output logic [127:0]          m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  busy,
    output logic [31:0]           loop_cntr
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND
    } state_t;

    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [ADDR_WIDTH:0]   len_q,       len_d;
    logic [31:0]           loops_q,     loops_d;
    logic [31:0]           loop_cntr_q, loop_cntr_d;
    logic                  tvalid_q,    tvalid_d;
    logic                  stop_pend_q, stop_pend_d;
    logic [127:0]          tdata_q;
    logic                  load_data;
    logic                  last_entry;
    logic                  final_pass;

    logic [112:0] mem_q [DEPTH];

    // Host writes go straight into the table. Reads happen only when the
    // output register loads. That load is a non-blocking sample, so a write
    // to the same address in the same cycle still returns the old entry.
    always_ff @(posedge aclk) begin
        if (cfg_wren) begin
            mem_q[cfg_addr] <= cfg_wdata;
        end
    end

    assign last_entry = ({1'b0, addr_q} == (len_q - 1'b1));
    assign final_pass = (loops_q != 32'd0) && ((loop_cntr_q + 32'd1) == loops_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        loops_d     = loops_q;
        loop_cntr_d = loop_cntr_q;
        tvalid_d    = tvalid_q;
        stop_pend_d = stop_pend_q;
        load_data   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                // A stop in the same cycle cancels the start request.
                if (start && !stop && (cfg_length != '0)) begin
                    len_d       = (cfg_length > DEPTH_L) ? DEPTH_L : cfg_length;
                    loops_d     = cfg_loops;
                    addr_d      = '0;
                    loop_cntr_d = 32'd0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    load_data = 1'b1;
                    tvalid_d  = 1'b1;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                // A stop cannot retract a presented beat. Remember the
                // request and leave once the beat has been accepted.
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (tvalid_q && m_axis_tready) begin
                    tvalid_d = 1'b0;
                    if (last_entry) begin
                        addr_d      = '0;
                        loop_cntr_d = loop_cntr_q + 32'd1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (stop || stop_pend_q || (last_entry && final_pass)) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                tvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            loops_q     <= 32'd0;
            loop_cntr_q <= 32'd0;
            tvalid_q    <= 1'b0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            loops_q     <= loops_d;
            loop_cntr_q <= loop_cntr_d;
            tvalid_q    <= tvalid_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    // The output register also acts as the registered table read port. It
    // loads only on leaving FETCH, so the beat holds steady throughout SEND.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tdata_q <= 128'd0;
        end else if (load_data) begin
            tdata_q <= {15'd0, mem_q[addr_q]};
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign busy          = (state_q != S_IDLE);
    assign loop_cntr     = loop_cntr_q;

endmodule

// File: tb/tb_axis_gate_sequencer.sv
module tb_axis_gate_sequencer;

    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;

    logic          aclk;
    logic          aresetn;
    logic          cfg_wren;
    logic [AW-1:0] cfg_addr;
    logic [112:0]  cfg_wdata;
    logic [AW:0]   cfg_length;
    logic [31:0]   cfg_loops;
    logic          start;
    logic          stop;
    logic          m_axis_tready;
    logic [127:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          busy;
    logic [31:0]   loop_cntr;

    axis_gate_sequencer #(.ADDR_WIDTH(AW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .cfg_wren      (cfg_wren),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_length    (cfg_length),
        .cfg_loops     (cfg_loops),
        .start         (start),
        .stop          (stop),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .busy          (busy),
        .loop_cntr     (loop_cntr)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic [112:0] tbl [DEPTH];
    logic [127:0] sb_q [$];
    int           n_vec = 0;
    int           n_err = 0;
    int           n_hs  = 0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data  = '0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pop on every handshake, plus AXI hold rules.
    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {127'd0, m_axis_tvalid}, 128'd1);
                chk("hold_data", m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_hs++;
                chk("sb_nonempty", {127'd0, (sb_q.size() != 0)}, 128'd1);
                if (sb_q.size() != 0) chk("beat", m_axis_tdata, sb_q.pop_front());
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [112:0] ent(input logic [63:0] dur, input logic [31:0] poff,
                                         input logic [15:0] lvl, input logic g);
        return {g, lvl, poff, dur};
    endfunction

    task automatic wr(input int a, input logic [112:0] d);
        cfg_wren  = 1'b1;
        cfg_addr  = a[AW-1:0];
        cfg_wdata = d;
        tbl[a]    = d;
        tick();
        cfg_wren  = 1'b0;
    endtask

    task automatic push_run(input int len, input int loops);
        for (int p = 0; p < loops; p++)
            for (int i = 0; i < len; i++)
                sb_q.push_back({15'd0, tbl[i]});
    endtask

    task automatic pulse_start(input int len, input int loops);
        cfg_length = len[AW:0];
        cfg_loops  = loops;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int max, input bit rnd);
        for (int i = 0; i < max && busy; i++) begin
            if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("idle_wait", {127'd0, busy}, 128'd0);
    endtask

    task automatic wait_valid(input int max);
        for (int i = 0; i < max && !m_axis_tvalid; i++) tick();
        chk("valid_wait", {127'd0, m_axis_tvalid}, 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int hs_run;
        aresetn       = 1'b0;
        cfg_wren      = 1'b0;
        cfg_addr      = '0;
        cfg_wdata     = '0;
        cfg_length    = '0;
        cfg_loops     = '0;
        start         = 1'b0;
        stop          = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_valid", {127'd0, m_axis_tvalid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_loops", {96'd0, loop_cntr}, 128'd0);
        chk("rst_data", m_axis_tdata, 128'd0);
        aresetn = 1'b1;
        tick();

        // Three entries, single pass, always ready, latency check.
        wr(0, ent(64'd10, 32'h100, 16'h1111, 1'b1));
        wr(1, ent(64'd20, 32'h200, 16'h2222, 1'b0));
        wr(2, ent(64'd30, 32'h300, 16'h3333, 1'b1));
        m_axis_tready = 1'b1;
        push_run(3, 1);
        pulse_start(3, 1);
        chk("lat_fetch_valid", {127'd0, m_axis_tvalid}, 128'd0);
        chk("lat_busy", {127'd0, busy}, 128'd1);
        tick();
        chk("lat_valid", {127'd0, m_axis_tvalid}, 128'd1);
        chk("lat_data", m_axis_tdata, {15'd0, tbl[0]});
        wait_idle(50, 1'b0);
        chk("t1_sb_empty", 128'(sb_q.size()), 128'd0);
        chk("t1_loops", {96'd0, loop_cntr}, 128'd1);

        // Two entries, four passes, random back-pressure.
        wr(0, ent(64'hA, 32'hAAAA, 16'hA0A0, 1'b1));
        wr(1, ent(64'hB, 32'hBBBB, 16'hB0B0, 1'b0));
        push_run(2, 4);
        pulse_start(2, 4);
        wait_idle(400, 1'b1);
        m_axis_tready = 1'b1;
        chk("t2_sb_empty", 128'(sb_q.size()), 128'd0);
        chk("t2_loops", {96'd0, loop_cntr}, 128'd4);

        // Endless mode, then stop while stalled.
        wr(0, ent(64'hC, 32'hCCCC, 16'hC0C0, 1'b1));
        push_run(1, 60);
        hs_run = n_hs;
        pulse_start(1, 0);
        repeat (10) tick();
        m_axis_tready = 1'b0;
        wait_valid(10);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_hold_valid", {127'd0, m_axis_tvalid}, 128'd1);
        chk("stop_hold_busy", {127'd0, busy}, 128'd1);
        tick();
        chk("stop_still_busy", {127'd0, busy}, 128'd1);
        hs0 = n_hs;
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        chk("stop_idle", {127'd0, busy}, 128'd0);
        chk("stop_drop_valid", {127'd0, m_axis_tvalid}, 128'd0);
        chk("stop_one_beat", 128'(n_hs - hs0), 128'd1);
        chk("inf_loops", {96'd0, loop_cntr}, 128'(n_hs - hs_run));
        repeat (3) tick();
        chk("stop_no_more", {127'd0, m_axis_tvalid}, 128'd0);
        sb_q.delete();

        // Zero-length start, start+stop, stop in FETCH, start while busy.
        m_axis_tready = 1'b1;
        pulse_start(0, 1);
        for (int i = 0; i < 3; i++) begin
            chk("len0_busy", {127'd0, busy}, 128'd0);
            chk("len0_valid", {127'd0, m_axis_tvalid}, 128'd0);
            tick();
        end
        cfg_length = 1;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("start_stop_busy", {127'd0, busy}, 128'd0);
        pulse_start(1, 1);
        chk("fetch_busy", {127'd0, busy}, 128'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("fetch_stop_busy", {127'd0, busy}, 128'd0);
        tick();
        chk("fetch_stop_valid", {127'd0, m_axis_tvalid}, 128'd0);
        push_run(2, 1);
        pulse_start(2, 1);
        tick();
        cfg_length = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(50, 1'b0);
        chk("busy_start_sb_empty", 128'(sb_q.size()), 128'd0);
        chk("busy_start_loops", {96'd0, loop_cntr}, 128'd1);

        // Asynchronous reset while a beat is pending, then replay.
        wr(2, ent(64'hE, 32'hEEEE, 16'hE0E0, 1'b0));
        m_axis_tready = 1'b0;
        pulse_start(3, 0);
        wait_valid(10);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_valid", {127'd0, m_axis_tvalid}, 128'd0);
        chk("arst_busy", {127'd0, busy}, 128'd0);
        chk("arst_loops", {96'd0, loop_cntr}, 128'd0);
        sb_q.delete();
        #20 aresetn = 1'b1;
        tick();
        push_run(3, 1);
        m_axis_tready = 1'b1;
        pulse_start(3, 1);
        tick();
        chk("replay_data", m_axis_tdata, {15'd0, tbl[0]});
        wait_idle(50, 1'b0);
        chk("replay_sb_empty", 128'(sb_q.size()), 128'd0);
        chk("replay_loops", {96'd0, loop_cntr}, 128'd1);

        // Oversized length clamps to the full table.
        for (int i = 0; i < DEPTH; i++)
            wr(i, ent(64'(100 + i), 32'(i * 3), 16'(i), i[0]));
        push_run(DEPTH, 1);
        pulse_start(2 * DEPTH - 1, 1);
        wait_idle(100, 1'b0);
        chk("clamp_sb_empty", 128'(sb_q.size()), 128'd0);
        chk("clamp_loops", {96'd0, loop_cntr}, 128'd1);

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
